// File: rtl/mem_pkg.sv
// mem_requester shared package
// opcodes, FSM encoding, default widths, op legality
package mem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 4;

   typedef logic [2:0] op_t;

   localparam op_t OP_NOP   = 3'd0;
   localparam op_t OP_READ  = 3'd1;
   localparam op_t OP_WRITE = 3'd2;
   localparam op_t OP_CLEAR = 3'd3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   function automatic logic op_is_legal(input op_t op);
      return (op == OP_READ) || (op == OP_WRITE) ||
             (op == OP_CLEAR);
   endfunction

endpackage

// File: rtl/mem_requester_if.sv
// mem_requester host + memory bundle
// master = host/memory side, slave = requester side
interface mem_requester_if
   import mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   op_t               req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   op_t               mem_operation;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_done;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      output resp_ready, mem_rdata, mem_done,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_operation, mem_address, mem_wdata
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      input  resp_ready, mem_rdata, mem_done,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_operation, mem_address, mem_wdata
   );

endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: load/count/expire cycle counter
// expire is high on the LIMIT-th enabled cycle after load
module mem_watchdog #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire = en && (cnt_q == CW'(LIMIT - 1));

   // next count: clear on load, advance while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (en && !expire) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_requester.sv
// mem_requester: host-to-scratch-memory command initiator
// define MEM_REQ_TIMEOUT_EN to add the S_WAIT watchdog
module mem_requester
   import mem_pkg::*;
#(
   parameter int DATA_W         = DATA_W_DEF,
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int OP_HOLD        = 2,
   parameter int TIMEOUT_CYCLES = 15
) (
   input logic            clk,
   input logic            rst_n,
   mem_requester_if.slave bus
);

   localparam int HW = $clog2(OP_HOLD + 1);

   logic [1:0]        state_q, state_d;
   op_t               op_q, op_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   op_t               mem_op_q, mem_op_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic wd_load;
   logic wd_expire;

`ifdef MEM_REQ_TIMEOUT_EN
   mem_watchdog #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wd (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (wd_load),
      .en     (state_q == S_WAIT),
      .expire (wd_expire)
   );
`else
   logic unused_wd;
   assign unused_wd = wd_load & (TIMEOUT_CYCLES > 0);
   assign wd_expire = 1'b0;
`endif

   assign bus.req_ready     = req_ready_q;
   assign bus.resp_valid    = resp_valid_q;
   assign bus.resp_rdata    = resp_rdata_q;
   assign bus.resp_err      = resp_err_q;
   assign bus.mem_operation = mem_op_q;
   assign bus.mem_address   = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;

   // command FSM: accept, hold op, await done, respond
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      hold_d       = hold_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      mem_op_d     = mem_op_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      wd_load      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               op_d = bus.req_op;
               if (op_is_legal(bus.req_op)) begin
                  mem_op_d    = bus.req_op;
                  mem_addr_d  = bus.req_addr;
                  mem_wdata_d = bus.req_wdata;
                  hold_d      = '0;
                  state_d     = S_ISSUE;
               end else begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
                  state_d      = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            if (hold_q == HW'(OP_HOLD - 1)) begin
               mem_op_d = OP_NOP;
               wd_load  = 1'b1;
               state_d  = S_WAIT;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         S_WAIT: begin
            if (bus.mem_done) begin
               resp_rdata_d = (op_q == OP_READ) ?
                              bus.mem_rdata : '0;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end else if (wd_expire) begin
               resp_rdata_d = '0;
               resp_err_d   = 1'b1;
               resp_valid_d = 1'b1;
               state_d      = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               resp_err_d   = 1'b0;
               resp_rdata_d = '0;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   // state and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         op_q         <= OP_NOP;
         hold_q       <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         mem_op_q     <= OP_NOP;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         hold_q       <= hold_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_op_q     <= mem_op_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed bench with 16x16 memory model
// model raises done one cycle after op drops (+model_dly)
module tb_mem_requester;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_requester_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   mem_requester #(
      .DATA_W(16), .ADDR_W(4),
      .OP_HOLD(2), .TIMEOUT_CYCLES(15)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic        model_en = 1'b1;
   int          model_dly = 0;
   logic        inj_done = 1'b0;
   logic [15:0] inj_rdata = '0;
   logic [15:0] mem_arr [16];
   logic [2:0]  pend_op = '0;
   logic [3:0]  pend_a = '0;
   logic [15:0] pend_d = '0;
   int          dly_cnt = 0;
   logic        model_done = 1'b0;
   logic [15:0] model_rdata = '0;

   assign bus.mem_done  = model_done | inj_done;
   assign bus.mem_rdata = inj_done ? inj_rdata : model_rdata;

   initial for (int i = 0; i < 16; i++) mem_arr[i] = '0;

   always @(posedge clk) begin
      model_done <= 1'b0;
      if (bus.mem_operation != 3'd0) begin
         pend_op <= bus.mem_operation;
         pend_a  <= bus.mem_address;
         pend_d  <= bus.mem_wdata;
         dly_cnt <= 0;
      end else if (pend_op != 3'd0) begin
         if (!model_en) begin
            pend_op <= '0;
         end else if (dly_cnt == model_dly) begin
            model_done <= 1'b1;
            pend_op    <= '0;
            if (pend_op == 3'd1) model_rdata <= mem_arr[pend_a];
            if (pend_op == 3'd2) mem_arr[pend_a] <= pend_d;
            if (pend_op == 3'd3)
               for (int i = 0; i < 16; i++) mem_arr[i] <= '0;
         end else begin
            dly_cnt <= dly_cnt + 1;
         end
      end
   end

   int          lat, oc, lb;
   logic [15:0] rd;
   logic        er;

   task automatic run_cmd(
      input  logic [2:0]  op,
      input  logic [3:0]  a,
      input  logic [15:0] d,
      output int          lat_o,
      output int          opcnt,
      output int          linebad,
      output logic [15:0] rd_o,
      output logic        er_o
   );
      int w;
      lat_o = -1; opcnt = 0; linebad = 0;
      rd_o = 'x; er_o = 1'bx;
      @(negedge clk);
      w = 0;
      while (bus.req_ready !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (bus.mem_operation !== 3'd0) begin
            opcnt++;
            if (bus.mem_operation !== op ||
                bus.mem_address !== a ||
                bus.mem_wdata !== d) linebad++;
         end
         if (bus.resp_valid === 1'b1) begin
            lat_o = i;
            rd_o  = bus.resp_rdata;
            er_o  = bus.resp_err;
            break;
         end
      end
   endtask

   task automatic ack();
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1 bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_req_ready: got %b want 0", bus.req_ready);
      end
      n_cmp++;
      if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_resp: got v=%b e=%b want 0 0",
                  bus.resp_valid, bus.resp_err);
      end
      n_cmp++;
      if (bus.resp_rdata !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_rdata: got %h want 0000", bus.resp_rdata);
      end
      n_cmp++;
      if (bus.mem_operation !== 3'd0 || bus.mem_address !== 4'd0 ||
          bus.mem_wdata !== 16'h0) begin
         n_bad++;
         $display("FAIL rst_mem: got op=%0d a=%0d d=%h want 0 0 0",
                  bus.mem_operation, bus.mem_address, bus.mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_idle_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_write_read();
      run_cmd(3'd2, 4'd5, 16'hBEEF, lat, oc, lb, rd, er);
      n_cmp++;
      if (oc !== 2 || lb !== 0) begin
         n_bad++;
         $display("FAIL wr_hold: got cycles=%0d badlines=%0d want 2 0",
                  oc, lb);
      end
      n_cmp++;
      if (lat !== 5 || rd !== 16'h0 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL wr_resp: got lat=%0d rd=%h e=%b want 5 0000 0",
                  lat, rd, er);
      end
      ack();
      run_cmd(3'd1, 4'd5, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (oc !== 2 || lb !== 0) begin
         n_bad++;
         $display("FAIL rd_hold: got cycles=%0d badlines=%0d want 2 0",
                  oc, lb);
      end
      n_cmp++;
      if (lat !== 5 || rd !== 16'hBEEF || er !== 1'b0) begin
         n_bad++;
         $display("FAIL rd_resp: got lat=%0d rd=%h e=%b want 5 beef 0",
                  lat, rd, er);
      end
      ack();
   endtask

   task automatic test_clear();
      run_cmd(3'd2, 4'd3, 16'h1234, lat, oc, lb, rd, er);
      ack();
      run_cmd(3'd3, 4'd9, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (lat !== 5 || rd !== 16'h0 || er !== 1'b0 || oc !== 2) begin
         n_bad++;
         $display("FAIL clr_resp: got lat=%0d rd=%h e=%b hold=%0d want 5 0000 0 2",
                  lat, rd, er, oc);
      end
      ack();
      run_cmd(3'd1, 4'd3, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (lat !== 5 || rd !== 16'h0 || er !== 1'b0) begin
         n_bad++;
         $display("FAIL clr_read: got lat=%0d rd=%h e=%b want 5 0000 0",
                  lat, rd, er);
      end
      ack();
   endtask

   task automatic test_illegal();
      logic [2:0] ops [2];
      ops[0] = 3'd0;
      ops[1] = 3'd5;
      for (int k = 0; k < 2; k++) begin
         run_cmd(ops[k], 4'd6, 16'h7777, lat, oc, lb, rd, er);
         n_cmp++;
         if (lat !== 1 || er !== 1'b1 || rd !== 16'h0 || oc !== 0) begin
            n_bad++;
            $display("FAIL illegal_op%0d: got lat=%0d e=%b rd=%h memop_cycles=%0d want 1 1 0000 0",
                     ops[k], lat, er, rd, oc);
         end
         ack();
      end
   endtask

   task automatic test_back_pressure();
      int bad;
      run_cmd(3'd2, 4'd7, 16'hA5A5, lat, oc, lb, rd, er);
      ack();
      run_cmd(3'd1, 4'd7, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (lat !== 5 || rd !== 16'hA5A5) begin
         n_bad++;
         $display("FAIL bp_first: got lat=%0d rd=%h want 5 a5a5", lat, rd);
      end
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
      bus.req_addr  = 4'd2;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'hA5A5 ||
             bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0 ||
             bus.mem_operation !== 3'd0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
      end
      bus.req_valid = 1'b0;
      ack();
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL bp_release: got v=%b rdy=%b want 0 1",
                  bus.resp_valid, bus.req_ready);
      end
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.mem_operation !== 3'd0 || bus.resp_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL bp_no_extra: got %0d active cycles want 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      model_en = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
      bus.req_addr  = 4'd7;
      bus.req_wdata = 16'h0;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.mem_operation !== 3'd0 || bus.resp_valid !== 1'b0 ||
          bus.mem_address !== 4'd7) begin
         n_bad++;
         $display("FAIL mid_wait: got op=%0d v=%b a=%0d want 0 0 7",
                  bus.mem_operation, bus.resp_valid, bus.mem_address);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_en = 1'b1;
      @(negedge clk);
      inj_done  = 1'b1;
      inj_rdata = 16'hDEAD;
      @(posedge clk);
      #1 inj_done = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 ||
             bus.resp_rdata !== 16'h0 || bus.mem_operation !== 3'd0 ||
             bus.mem_address !== 4'd0 || bus.mem_wdata !== 16'h0 ||
             bus.req_ready !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL mid_reset: got %0d non-reset cycles want 0", bad);
      end
   endtask

`ifdef MEM_REQ_TIMEOUT_EN
   task automatic test_timeout();
      model_en = 1'b0;
      run_cmd(3'd1, 4'd7, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (lat !== 18 || er !== 1'b1 || rd !== 16'h0) begin
         n_bad++;
         $display("FAIL timeout: got lat=%0d e=%b rd=%h want 18 1 0000",
                  lat, er, rd);
      end
      ack();
      model_en  = 1'b1;
      model_dly = 13;
      run_cmd(3'd1, 4'd7, 16'h0, lat, oc, lb, rd, er);
      n_cmp++;
      if (lat !== 18 || er !== 1'b0 || rd !== 16'hA5A5) begin
         n_bad++;
         $display("FAIL done_at_limit: got lat=%0d e=%b rd=%h want 18 0 a5a5",
                  lat, er, rd);
      end
      ack();
      model_dly = 0;
   endtask
`else
   task automatic test_wait_forever();
      int bad;
      model_en = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
      bus.req_addr  = 4'd7;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.resp_valid !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL wait_forever: got %0d early resp cycles want 0", bad);
      end
      inj_done  = 1'b1;
      inj_rdata = 16'h5A5A;
      @(posedge clk);
      #1 inj_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 16'h5A5A ||
          bus.resp_err !== 1'b0) begin
         n_bad++;
         $display("FAIL late_done: got v=%b rd=%h e=%b want 1 5a5a 0",
                  bus.resp_valid, bus.resp_rdata, bus.resp_err);
      end
      ack();
      model_en = 1'b1;
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "bench stalled");
   end

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_op     = 3'd0;
      bus.req_addr   = 4'd0;
      bus.req_wdata  = 16'h0;
      bus.resp_ready = 1'b0;
      test_reset();
      test_write_read();
      test_clear();
      test_illegal();
      test_back_pressure();
      test_reset_mid();
`ifdef MEM_REQ_TIMEOUT_EN
      test_timeout();
`else
      test_wait_forever();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_requester.md
Name: mem_requester

Overview:
Initiator side of the 16x16 scratch-memory command interface. Accepts one host request at a time (read, write or clear) over a valid/ready handshake. Drives the memory's operation/address/data lines with the required hold timing, then waits for the memory's one-cycle done pulse. Returns read data or completion status on a valid/ready response channel. Sits between the controller/datapath and the memory block.

Parameters:
DATA_W, 16, data word width (matches memory).
ADDR_W, 4, address width (16 words).
OP_HOLD, 2, cycles mem_operation is held non-zero per command; minimum legal value is 2.
TIMEOUT_CYCLES, 15, WAIT cycles without done before error; used only with MEM_REQ_TIMEOUT_EN.

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous reset, active low.
req_valid  in  1  host request present.
req_ready  out  1  block can accept a request.
req_op  in  3  1=read, 2=write, 3=clear; 0 and 4-7 are illegal.
req_addr  in  ADDR_W  word address (ignored for clear).
req_wdata  in  DATA_W  write data (write only).
resp_valid  out  1  response present.
resp_ready  in  1  host accepts response.
resp_rdata  out  DATA_W  read data; 0 for write/clear/error.
resp_err  out  1  illegal op or timeout.
mem_operation  out  3  to memory operation input.
mem_address  out  ADDR_W  to memory address.
mem_wdata  out  DATA_W  to memory data_in.
mem_rdata  in  DATA_W  from memory data_out.
mem_done  in  1  from memory done (one-cycle pulse).

Behaviour:
- Reset (rst_n low at clk edge): state=S_IDLE, req_ready=0 that cycle then 1 in S_IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_operation=0, mem_address=0, mem_wdata=0, counters=0. Reset mid-command abandons it; a later mem_done is ignored because done is sampled only in S_WAIT.
- req_ready=1 only in S_IDLE. Accept on req_valid&req_ready at edge T; latch op/addr/wdata.
- S_IDLE: on accept with legal op -> S_ISSUE; with illegal op -> S_RESP with resp_err=1, memory lines untouched.
- S_ISSUE: mem_operation=latched op, mem_address/mem_wdata=latched values for exactly OP_HOLD cycles (T+1..T+OP_HOLD), then mem_operation=0 -> S_WAIT. Address/wdata stay stable until S_RESP.
- S_WAIT: mem_operation=0. On mem_done=1: capture mem_rdata into resp_rdata (read only, else 0), resp_err=0 -> S_RESP. With OP_HOLD=2, done arrives at T+4 and resp_valid rises at T+5.
- S_RESP: resp_valid=1, outputs held stable until resp_ready=1 at an edge -> S_IDLE. resp_valid and req_ready are never high together, so there is at most one outstanding command.
- mem_done outside S_WAIT is ignored, with no state change.
- mem_done in the same cycle as the timeout limit is reached: done wins, normal response.

Optional Feature:
MEM_REQ_TIMEOUT_EN: when defined, a watchdog counts S_WAIT cycles. Reaching TIMEOUT_CYCLES without mem_done -> S_RESP with resp_err=1, resp_rdata=0. The counter clears on entry to S_WAIT. When undefined, S_WAIT waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package mem_pkg: op codes OP_NOP=0, OP_READ=1, OP_WRITE=2, OP_CLEAR=3; the op_is_legal function; state encoding S_IDLE/S_ISSUE/S_WAIT/S_RESP; default widths.
- One sub-module, mem_watchdog (load/count/expire counter), instantiated only under MEM_REQ_TIMEOUT_EN.

Test Plan:
- Write addr 5 data 16'hBEEF, then read addr 5 -> mem_operation=2 for exactly 2 cycles; read response resp_rdata=16'hBEEF, resp_err=0, resp_valid at T+5 of the read accept.
- Write addr 3=16'h1234, clear, read addr 3 -> resp_rdata=16'h0000; clear response has resp_rdata=0, resp_err=0.
- req_op=0 and req_op=5 -> resp_err=1 next cycle; mem_operation stays 0 throughout.
- Hold resp_ready=0 for 10 cycles after a read of 16'hA5A5 -> resp_valid/resp_rdata stable, req_ready=0, extra req_valid not accepted.
- Drop rst_n during S_WAIT, inject mem_done after reset -> all outputs at reset values, no resp_valid.
- MEM_REQ_TIMEOUT_EN with memory stubbed never asserting done -> resp_err=1 after 15 S_WAIT cycles; also done on the 15th cycle -> normal response.
